// File: rtl/flopr_checker.sv
// Self-checking driver for a 1-cycle flopr: drives 0..NVEC-1 on d, checks q one
// cycle later, and reports error count, first failing vector and pass/fail.
module flopr_checker #(
    parameter int unsigned N    = 64,
    parameter int unsigned NVEC = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [N-1:0]                q,
    output logic [N-1:0]                d,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [$clog2(NVEC+1)-1:0]   err_count,
    output logic [$clog2(NVEC)-1:0]     first_err_idx,
    output logic                        err_seen
);

    localparam int unsigned IW = $clog2(NVEC);
    localparam int unsigned CW = $clog2(NVEC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [IW-1:0] first_err_idx_q, first_err_idx_d;
    logic          err_seen_q, err_seen_d;
    logic          mismatch;
    logic [IW-1:0] chk_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            err_seen_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            err_seen_q      <= err_seen_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        err_seen_d      = err_seen_q;
        mismatch        = 1'b0;
        chk_idx         = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_RUN;
                    idx_d           = '0;
                    err_count_d     = '0;
                    first_err_idx_d = '0;
                    err_seen_d      = 1'b0;
                end
            end
            S_RUN: begin
                idx_d = idx_q + IW'(1);
                // q lags d by one cycle, so this cycle checks the previous vector
                if (idx_q != '0) begin
                    chk_idx  = idx_q - IW'(1);
                    mismatch = (q != N'(chk_idx));
                end
                if (idx_q == IW'(NVEC - 1)) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                chk_idx  = IW'(NVEC - 1);
                mismatch = (q != N'(NVEC - 1));
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (mismatch) begin
            if (err_count_q != CW'(NVEC)) begin
                err_count_d = err_count_q + CW'(1);
            end
            if (!err_seen_q) begin
                err_seen_d      = 1'b1;
                first_err_idx_d = chk_idx;
            end
        end
    end

    always_comb begin
        d    = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN: begin
                d    = N'(idx_q);
                busy = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign err_seen      = err_seen_q;
    assign pass          = done && (err_count_q == '0);

endmodule
